// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch program counter.
package pc_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_REDIR,
    SEL_PEND,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;

  localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_0080;
  localparam int          INST_BYTES_DEF = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with target alignment and misalign detection (purely combinational).
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int             AW         = 32,
  parameter int             INST_BYTES = INST_BYTES_DEF,
  parameter logic [AW-1:0]  EXC_VEC    = AW'(EXC_VEC_DEF)
) (
  input  logic          run,
  input  logic          advance,
  input  logic          exc_req,
  input  logic          eret,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  input  logic          pend_valid,
  input  logic [AW-1:0] pend_target,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] pc_plus,
  input  logic [AW-1:0] epc,
  output pc_sel_e       sel,
  output logic [AW-1:0] next_pc,
  output logic          misalign
);

  // INST_BYTES is a power of two, so clearing its low bits aligns a target.
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(INST_BYTES - 1);

  logic [AW-1:0] raw;
  logic          apply;

  always_comb begin
    sel   = SEL_HOLD;
    raw   = pc;
    apply = 1'b0;
    if (run) begin
      if (exc_req) begin
        sel   = SEL_EXC;
        raw   = EXC_VEC;
        apply = 1'b1;
      end else if (eret) begin
        sel   = SEL_ERET;
        raw   = epc;
        apply = 1'b1;
      end else if (redirect_valid && advance) begin
        sel   = SEL_REDIR;
        raw   = redirect_target;
        apply = 1'b1;
      end else if (pend_valid && advance) begin
        sel   = SEL_PEND;
        raw   = pend_target;
        apply = 1'b1;
      end else if (advance) begin
        sel   = SEL_SEQ;
        raw   = pc_plus;
      end
    end
  end

  assign next_pc  = apply ? (raw & ALIGN_MASK) : raw;
  assign misalign = apply & (|(raw & ~ALIGN_MASK));

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: vectors, EPC, eret, fetch handshake, pending redirect.
// Optional PC_PERF_EN adds perf_fetch / perf_stall counters.
//   state | meaning
//   BOOT  | first cycle after reset, no fetch request
//   RUN   | pc presented as a valid fetch request
module pc_gen
  import pc_pkg::*;
#(
  parameter int          AW         = 32,
  parameter logic [31:0] RESET_VEC  = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter int          INST_BYTES = INST_BYTES_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          stall,
  output logic          fetch_valid,
  input  logic          fetch_ready,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  input  logic          exc_req,
  input  logic [AW-1:0] exc_pc,
  input  logic          eret,
  output logic [AW-1:0] epc,
  output logic          misalign
`ifdef PC_PERF_EN
  ,
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_stall
`endif
);

  pc_state_e     state, state_nxt;
  pc_sel_e       sel;
  logic [AW-1:0] next_pc;
  logic          mis_nxt;
  logic          advance;
  logic          pend_valid;
  logic [AW-1:0] pend_target;
  logic          pend_load;

  assign fetch_valid = (state == RUN);
  assign advance     = fetch_valid & fetch_ready & ~stall;
  assign pc_plus     = pc + AW'(INST_BYTES);
  // Target raised while the request cannot advance is parked until it can.
  assign pend_load   = fetch_valid & redirect_valid & ~advance & ~exc_req & ~eret;

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  pc_next_sel #(
    .AW         (AW),
    .INST_BYTES (INST_BYTES),
    .EXC_VEC    (AW'(EXC_VEC))
  ) u_next_sel (
    .run             (fetch_valid),
    .advance         (advance),
    .exc_req         (exc_req),
    .eret            (eret),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target),
    .pc              (pc),
    .pc_plus         (pc_plus),
    .epc             (epc),
    .sel             (sel),
    .next_pc         (next_pc),
    .misalign        (mis_nxt)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= BOOT;
      pc          <= AW'(RESET_VEC);
      epc         <= '0;
      misalign    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= next_pc;
      misalign <= mis_nxt;
      if (sel == SEL_EXC)
        epc <= exc_pc;
      if (sel == SEL_EXC || sel == SEL_ERET || sel == SEL_REDIR || sel == SEL_PEND) begin
        pend_valid <= 1'b0;
      end else if (pend_load) begin
        pend_valid  <= 1'b1;
        pend_target <= redirect_target;
      end
    end
  end

`ifdef PC_PERF_EN
  always_ff @(posedge clk) begin
    if (!clrn) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (advance)
        perf_fetch <= perf_fetch + 32'd1;
      if (fetch_valid && !advance)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
